// File: rtl/irq_stub_pkg.sv
// Shared types and constants for the interrupt source stub and the CPU stub
// that talks to it.
package irq_stub_pkg;

  // Handshake phases of one interrupt round trip.
  typedef enum logic [2:0] {
    IDLE,
    ASSERT,
    WAIT_HANDLER,
    WAIT_RETURN,
    GAP,
    DONE,
    ERROR
  } state_t;

  // Addresses the CPU stub must agree on.
  localparam logic [31:0] DEFAULT_ACK_ADDR   = 32'h0000_7F20;
  localparam logic [31:0] DEFAULT_HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] DEFAULT_TRIGGER_PC = 32'h0000_3010;

  // Width of the shared phase timer.
  localparam int TIMER_W = 16;

endpackage

// File: rtl/irq_watchdog_timer.sv
// Saturating up-counter with a programmable expiry point. One instance is
// shared by all timed phases; the owner picks the limit per phase.
module irq_watchdog_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic [W-1:0] count,
  output logic         expired
);

  // Count up while enabled, hold at all-ones, restart on clear or reset.
  always_ff @(posedge clk) begin
    // NOTE: registers take <= so every flop samples pre-edge values, no
    // matter how the always blocks are ordered by the simulator.
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + W'(1);
    end
  end

  // Expired on the last cycle of the window, i.e. count == limit-1.
  assign expired = (count == (limit - W'(1)));

endmodule

// File: rtl/irq_source_stub.sv
// Device end of the CPU interrupt handshake: raises `interrupt` at a trigger
// PC, waits for an acknowledge write, then watches the CPU enter and leave
// the handler. Protocol violations raise sticky error flags.
module irq_source_stub
  import irq_stub_pkg::*;
#(
  parameter logic [31:0] ACK_ADDR        = DEFAULT_ACK_ADDR,
  parameter logic [31:0] TRIGGER_PC      = DEFAULT_TRIGGER_PC,
  parameter logic [31:0] HANDLER_PC      = DEFAULT_HANDLER_PC,
  parameter int          ACK_TIMEOUT     = 16,
  parameter int          HANDLER_TIMEOUT = 64,
  parameter int          REARM_GAP       = 8,
  parameter int          MAX_IRQS        = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] macroscopic_pc,
  input  logic [31:0] m_data_addr,
  input  logic [3:0]  m_data_byteen,
  output logic        interrupt,
  output logic [7:0]  irq_count,
  output logic        busy,
  output logic        done,
  output logic        err_ack_timeout,
  output logic        err_handler_timeout,
  output logic        err_spurious_ack
);

  localparam logic [TIMER_W-1:0] ACK_LIMIT     = TIMER_W'(ACK_TIMEOUT);
  localparam logic [TIMER_W-1:0] HANDLER_LIMIT = TIMER_W'(HANDLER_TIMEOUT);
  localparam logic [TIMER_W-1:0] GAP_LIMIT     = TIMER_W'(REARM_GAP);
  localparam logic [7:0]         MAX_CNT       = 8'(MAX_IRQS);

  state_t               state;
  logic                 ack;
  logic                 timer_clear;
  logic                 timer_enable;
  logic [TIMER_W-1:0]   timer_limit;
  logic [TIMER_W-1:0]   timer_count;
  logic                 timer_expired;
  logic                 timer_overdue;

  assign ack = (m_data_addr == ACK_ADDR) && (m_data_byteen != 4'b0000);

  // Past-limit also counts: the handler window can run past its last cycle
  // when the WAIT_HANDLER -> WAIT_RETURN step wins on that very cycle.
  assign timer_overdue = timer_expired || (timer_count >= timer_limit);

  // Timer control: restart on every phase entry, count inside timed phases.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    timer_clear  = 1'b0;
    timer_enable = 1'b0;
    timer_limit  = ACK_LIMIT;
    unique case (state)
      ASSERT: begin
        timer_limit  = ACK_LIMIT;
        timer_clear  = ack;
        timer_enable = !ack;
      end
      WAIT_HANDLER: begin
        timer_limit  = HANDLER_LIMIT;
        timer_enable = 1'b1;
      end
      WAIT_RETURN: begin
        timer_limit  = HANDLER_LIMIT;
        timer_clear  = (macroscopic_pc < HANDLER_PC);
        timer_enable = !(macroscopic_pc < HANDLER_PC);
      end
      GAP: begin
        timer_limit  = GAP_LIMIT;
        timer_enable = 1'b1;
      end
      default: begin
        timer_clear = 1'b1;
      end
    endcase
  end

  irq_watchdog_timer #(
    .W (TIMER_W)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .limit   (timer_limit),
    .count   (timer_count),
    .expired (timer_expired)
  );

  // Handshake FSM with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      interrupt           <= 1'b0;
      irq_count           <= 8'd0;
      busy                <= 1'b0;
      done                <= 1'b0;
      err_ack_timeout     <= 1'b0;
      err_handler_timeout <= 1'b0;
      err_spurious_ack    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ack) err_spurious_ack <= 1'b1;
          if ((macroscopic_pc == TRIGGER_PC) && (irq_count < MAX_CNT)) begin
            state     <= ASSERT;
            interrupt <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ASSERT: begin
          if (ack) begin
            interrupt <= 1'b0;
            if (irq_count < MAX_CNT) irq_count <= irq_count + 8'd1;
            state     <= WAIT_HANDLER;
          end else if (timer_overdue) begin
            interrupt       <= 1'b0;
            err_ack_timeout <= 1'b1;
            busy            <= 1'b0;
            state           <= ERROR;
          end
        end
        WAIT_HANDLER: begin
          if (macroscopic_pc == HANDLER_PC) begin
            state <= WAIT_RETURN;
          end else if (timer_overdue) begin
            err_handler_timeout <= 1'b1;
            busy                <= 1'b0;
            state               <= ERROR;
          end
        end
        WAIT_RETURN: begin
          if (ack) err_spurious_ack <= 1'b1;
          if (macroscopic_pc < HANDLER_PC) begin
            state <= GAP;
          end else if (timer_overdue) begin
            err_handler_timeout <= 1'b1;
            busy                <= 1'b0;
            state               <= ERROR;
          end
        end
        GAP: begin
          if (ack) err_spurious_ack <= 1'b1;
          if (timer_overdue) begin
            busy <= 1'b0;
            if (irq_count == MAX_CNT) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              state <= IDLE;
            end
          end
        end
        DONE: begin
          if (ack) err_spurious_ack <= 1'b1;
          interrupt <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
        end
        default: begin
          interrupt <= 1'b0;
          busy      <= 1'b0;
          state     <= ERROR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_source_stub.sv
// Directed bench for irq_source_stub: handshake timing, gap re-arm, all
// error paths, mid-operation reset and the DONE state.
module tb_irq_source_stub;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] macroscopic_pc;
  logic [31:0] m_data_addr;
  logic [3:0]  m_data_byteen;
  logic        interrupt;
  logic [7:0]  irq_count;
  logic        busy;
  logic        done;
  logic        err_ack_timeout;
  logic        err_handler_timeout;
  logic        err_spurious_ack;

  int checks   = 0;
  int failures = 0;

  irq_source_stub dut (
    .clk                 (clk),
    .reset               (reset),
    .macroscopic_pc      (macroscopic_pc),
    .m_data_addr         (m_data_addr),
    .m_data_byteen       (m_data_byteen),
    .interrupt           (interrupt),
    .irq_count           (irq_count),
    .busy                (busy),
    .done                (done),
    .err_ack_timeout     (err_ack_timeout),
    .err_handler_timeout (err_handler_timeout),
    .err_spurious_ack    (err_spurious_ack)
  );

  always #5 clk = ~clk;

  // One clock edge, then settle 1 ns so outputs are read away from the edge.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ack(input logic [3:0] be, input logic [31:0] addr = 32'h0000_7F20);
    m_data_addr   = addr;
    m_data_byteen = be;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    step(1);
    reset = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_int"},  {31'd0, interrupt}, 32'd0);
    check({tag, "_cnt"},  {24'd0, irq_count}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_errs"}, {29'd0, err_ack_timeout, err_handler_timeout, err_spurious_ack}, 32'd0);
  endtask

  initial begin
    reset          = 1'b1;
    macroscopic_pc = 32'h0000_0000;
    set_ack(4'b0000, 32'h0);
    step(2);
    reset = 1'b0;
    check_all_zero("reset");

    // Trigger timing: PC walks up to the trigger address.
    macroscopic_pc = 32'h3000; step(1);
    macroscopic_pc = 32'h3004; step(1);
    macroscopic_pc = 32'h3008; step(1);
    macroscopic_pc = 32'h300C; step(1);
    check("pre_trigger_int", {31'd0, interrupt}, 32'd0);
    macroscopic_pc = 32'h3010; step(1);
    check("trigger_int", {31'd0, interrupt}, 32'd1);
    check("trigger_busy", {31'd0, busy}, 32'd1);
    macroscopic_pc = 32'h3014; step(1);
    check("assert_hold", {31'd0, interrupt}, 32'd1);
    set_ack(4'b1111); macroscopic_pc = 32'h3018; step(1);
    check("ack_int_fall", {31'd0, interrupt}, 32'd0);
    check("ack_count1", {24'd0, irq_count}, 32'd1);
    // Re-ack while waiting for the handler is tolerated.
    step(1);
    check("reack_ignored", {31'd0, err_spurious_ack}, 32'd0);
    set_ack(4'b0000, 32'h0);
    macroscopic_pc = 32'h4180; step(1);
    macroscopic_pc = 32'h4184; step(1);
    macroscopic_pc = 32'h3010; step(1);  // return -> GAP, trigger PC held
    step(7);
    check("gap_busy", {31'd0, busy}, 32'd1);
    check("gap_no_fire", {31'd0, interrupt}, 32'd0);
    step(1);
    check("gap_exit_busy", {31'd0, busy}, 32'd0);
    check("gap_exit_int", {31'd0, interrupt}, 32'd0);
    step(1);
    check("rearm_fire", {31'd0, interrupt}, 32'd1);
    set_ack(4'b0100); macroscopic_pc = 32'h3014; step(1);
    check("ack_count2", {24'd0, irq_count}, 32'd2);
    set_ack(4'b0000, 32'h0);
    macroscopic_pc = 32'h4180; step(1);
    macroscopic_pc = 32'h4188; step(1);  // in WAIT_RETURN, count 2

    // Mid-operation reset, then normal re-fire.
    do_reset;
    check_all_zero("midreset");
    macroscopic_pc = 32'h3010; step(1);
    check("postreset_fire", {31'd0, interrupt}, 32'd1);

    // Ack timeout: interrupt high for 16 cycles, then ERROR.
    do_reset;
    macroscopic_pc = 32'h3010; step(1);
    macroscopic_pc = 32'h3014; step(15);
    check("acktmo_still_high", {31'd0, interrupt}, 32'd1);
    check("acktmo_no_err_yet", {31'd0, err_ack_timeout}, 32'd0);
    step(1);
    check("acktmo_int", {31'd0, interrupt}, 32'd0);
    check("acktmo_err", {31'd0, err_ack_timeout}, 32'd1);
    check("acktmo_busy", {31'd0, busy}, 32'd0);
    set_ack(4'b1111); step(1);
    check("acktmo_late_cnt", {24'd0, irq_count}, 32'd0);
    check("acktmo_late_spur", {31'd0, err_spurious_ack}, 32'd0);
    set_ack(4'b0000, 32'h0);

    // Handler timeout: handler PC never reached.
    do_reset;
    macroscopic_pc = 32'h3010; step(1);
    set_ack(4'b0011); macroscopic_pc = 32'h3014; step(1);
    set_ack(4'b0000, 32'h0); macroscopic_pc = 32'h5000;
    step(63);
    check("hdltmo_not_yet", {31'd0, err_handler_timeout}, 32'd0);
    check("hdltmo_busy_before", {31'd0, busy}, 32'd1);
    step(1);
    check("hdltmo_err", {31'd0, err_handler_timeout}, 32'd1);
    check("hdltmo_busy", {31'd0, busy}, 32'd0);
    macroscopic_pc = 32'h3010; step(2);
    check("hdltmo_absorb", {31'd0, interrupt}, 32'd0);

    // Spurious acknowledges in IDLE.
    do_reset;
    macroscopic_pc = 32'h0;
    set_ack(4'b0000); step(1);
    check("spur_be0", {31'd0, err_spurious_ack}, 32'd0);
    set_ack(4'b1111, 32'h7F24); step(1);
    check("spur_wrong_addr", {31'd0, err_spurious_ack}, 32'd0);
    set_ack(4'b0001); step(1);
    check("spur_flag", {31'd0, err_spurious_ack}, 32'd1);
    check("spur_cnt", {24'd0, irq_count}, 32'd0);
    set_ack(4'b0000, 32'h0); step(1);
    check("spur_sticky", {31'd0, err_spurious_ack}, 32'd1);

    // Four full round trips lead to DONE.
    do_reset;
    for (int i = 0; i < 4; i++) begin
      macroscopic_pc = 32'h3010; step(1);
      set_ack(4'b1000); macroscopic_pc = 32'h3014; step(1);
      set_ack(4'b0000, 32'h0);
      macroscopic_pc = 32'h4180; step(1);
      macroscopic_pc = 32'h3000; step(1);
      step(8);
      check($sformatf("trip%0d_cnt", i), {24'd0, irq_count}, i + 1);
    end
    check("done_flag", {31'd0, done}, 32'd1);
    check("done_busy", {31'd0, busy}, 32'd0);
    check("done_errs", {29'd0, err_ack_timeout, err_handler_timeout, err_spurious_ack}, 32'd0);
    macroscopic_pc = 32'h3010; step(3);
    check("done_no_int", {31'd0, interrupt}, 32'd0);
    check("done_cnt_hold", {24'd0, irq_count}, 32'd4);
    set_ack(4'b1111); step(1);
    check("done_spur", {31'd0, err_spurious_ack}, 32'd1);
    set_ack(4'b0000, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
